// File: rtl/shiftup_pkg.sv
// shiftup_pkg: shared bus field layout and FSM state type for the shift_up feeder
package shiftup_pkg;
    localparam int CRU_W         = 135;
    localparam int CRU_VLD_BIT   = 134;
    localparam int CRU_DATA_MSB  = 133;
    localparam int CRU_DATA_LSB  = 6;
    localparam int CRU_ID_MSB    = 5;
    localparam int CRU_ID_LSB    = 1;
    localparam int CRU_BCAST_BIT = 0;
    localparam int SMC_ID_W      = 5;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/shiftup_fifo.sv
// shiftup_fifo: synchronous power-of-two FIFO with full/empty/level
//   clk, rst      clock, async active-high reset
//   push, wdata   write request (ignored when full)
//   pop, rdata    read request (ignored when empty); rdata shows the head word
//   full, empty   occupancy flags
//   level         current occupancy
module shiftup_fifo
    import shiftup_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = level == LVL_W'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(do_push);
            rd_ptr <= rd_ptr + PTR_W'(do_pop);
            level  <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/shiftup_issue.sv
// shiftup_issue: buffers payload words and serialises issue commands onto the cru_shiftup bus
//   clk, rst                      clock, async active-high reset
//   wr_vld, wr_rdy, wr_data       payload word handshake into the FIFO
//   cmd_vld, cmd_rdy              issue command handshake (accepted only in IDLE)
//   cmd_smc_id, cmd_word_cnt,     first SMC ID, words to issue (0 legal),
//   cmd_broadcast                 broadcast flag for the whole command
//   cru_shiftup_out               registered {vld, data, smc_id, broadcast}
//   done                          one-cycle pulse when a command completes
//   fifo_level                    FIFO occupancy
//   SHIFTUP_ISSUE_GAP_EN          when defined, a bubble cycle follows every issued word
module shiftup_issue
    import shiftup_pkg::*;
#(
    parameter int DATA_W            = 128,
    parameter int FIFO_DEPTH        = 8,
    parameter int PARAM_UR_WORD_CNT = 4,
    localparam int CNT_W = $clog2(PARAM_UR_WORD_CNT + 1),
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_vld,
    output logic                wr_rdy,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                cmd_vld,
    output logic                cmd_rdy,
    input  logic [SMC_ID_W-1:0] cmd_smc_id,
    input  logic [CNT_W-1:0]    cmd_word_cnt,
    input  logic                cmd_broadcast,
    output logic [CRU_W-1:0]    cru_shiftup_out,
    output logic                done,
    output logic [LVL_W-1:0]    fifo_level
);
`ifdef SHIFTUP_ISSUE_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    state_t              state;
    logic [CNT_W-1:0]    rem;
    logic [SMC_ID_W-1:0] id_r;
    logic                bcast_r;
    logic                gap;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [DATA_W-1:0]   fifo_rdata;

    assign wr_rdy  = ~fifo_full;
    assign cmd_rdy = state == IDLE;
    assign pop     = (state == ISSUE) & ~fifo_empty & ~gap;

    shiftup_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_vld),
        .wdata (wr_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // id_r advances per word instead of keeping a word index, so mod-32 wrap is free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rem             <= '0;
            id_r            <= '0;
            bcast_r         <= 1'b0;
            gap             <= 1'b0;
            cru_shiftup_out <= '0;
            done            <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cmd_vld) begin
                    id_r    <= cmd_smc_id;
                    bcast_r <= cmd_broadcast;
                    rem     <= cmd_word_cnt;
                    gap     <= 1'b0;
                    state   <= cmd_word_cnt == '0 ? DONE : ISSUE;
                end
                ISSUE: begin
                    cru_shiftup_out[CRU_VLD_BIT] <= pop;
                    gap <= pop & GAP_EN;
                    if (pop) begin
                        cru_shiftup_out[CRU_DATA_MSB:CRU_DATA_LSB] <= fifo_rdata;
                        cru_shiftup_out[CRU_ID_MSB:CRU_ID_LSB]     <= id_r;
                        cru_shiftup_out[CRU_BCAST_BIT]             <= bcast_r;
                        id_r  <= bcast_r ? id_r : id_r + SMC_ID_W'(1);
                        rem   <= rem - CNT_W'(1);
                        state <= rem == CNT_W'(1) ? DONE : ISSUE;
                    end
                end
                DONE: begin
                    done                         <= 1'b1;
                    cru_shiftup_out[CRU_VLD_BIT] <= 1'b0;
                    state                        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shiftup_issue.sv
// tb_shiftup_issue: randomized self-checking bench against a queue-based reference model
module tb_shiftup_issue;
`ifdef SHIFTUP_ISSUE_GAP_EN
    localparam bit GAP = 1'b1;
`else
    localparam bit GAP = 1'b0;
`endif
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_vld = 1'b0;
    logic         wr_rdy;
    logic [127:0] wr_data = '0;
    logic         cmd_vld = 1'b0;
    logic         cmd_rdy;
    logic [4:0]   cmd_smc_id = '0;
    logic [2:0]   cmd_word_cnt = '0;
    logic         cmd_broadcast = 1'b0;
    logic [134:0] cru;
    logic         done;
    logic [3:0]   fifo_level;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] mq[$];
    logic [133:0] last = '0;

    shiftup_issue dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .wr_data(wr_data),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_smc_id(cmd_smc_id),
        .cmd_word_cnt(cmd_word_cnt), .cmd_broadcast(cmd_broadcast),
        .cru_shiftup_out(cru), .done(done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock edge: model FIFO push/pop and check all outputs afterwards
    task automatic step(input bit exp_pop, input bit exp_done, input logic [4:0] eid, input bit ebc);
        bit pushed;
        logic [127:0] w;
        logic [127:0] ew;
        pushed = wr_vld && mq.size() < 8;
        w = wr_data;
        @(posedge clk);
        #1;
        wr_vld = 1'b0;
        chk("vld", cru[134], exp_pop);
        chk("done", done, exp_done);
        if (exp_pop) begin
            ew = mq.pop_front();
            chk("data", cru[133:6], ew);
            chk("id", cru[5:1], eid);
            chk("bcast", cru[0], ebc);
            last = cru[133:0];
        end else chk("hold", cru[133:0], last);
        if (pushed) mq.push_back(w);
        chk("level", fifo_level, mq.size());
        chk("wr_rdy", wr_rdy, mq.size() < 8);
    endtask

    task automatic push_word(input logic [127:0] w);
        wr_vld = 1'b1;
        wr_data = w;
        step(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic issue(input logic [4:0] id, input int cnt, input bit bc, input int push_at, input int push_n);
        int rem;
        int t;
        bit gap;
        bit ep;
        bit seen_done;
        logic [4:0] cur;
        chk("cmd_rdy_idle", cmd_rdy, 1'b1);
        cmd_vld = 1'b1;
        cmd_smc_id = id;
        cmd_word_cnt = 3'(cnt);
        cmd_broadcast = bc;
        step(1'b0, 1'b0, '0, 1'b0);
        rem = cnt;
        cur = id;
        gap = 1'b0;
        seen_done = 1'b0;
        t = 0;
        while (t < 64 && !seen_done) begin
            t++;
            // garbage on the command port must be ignored while busy
            cmd_vld = 1'($urandom);
            cmd_smc_id = 5'($urandom);
            cmd_word_cnt = 3'($urandom);
            cmd_broadcast = 1'($urandom);
            if (t >= push_at && t < push_at + push_n) begin
                wr_vld = 1'b1;
                wr_data = {$urandom, $urandom, $urandom, $urandom};
            end
            if (rem == 0) begin
                step(1'b0, 1'b1, '0, 1'b0);
                seen_done = 1'b1;
            end else begin
                ep = mq.size() > 0 && !gap;
                step(ep, 1'b0, cur, bc);
                gap = ep && GAP;
                if (ep) begin
                    rem--;
                    cur = bc ? cur : cur + 5'd1;
                end
            end
        end
        cmd_vld = 1'b0;
        chk("words_left", rem, 0);
        chk("done_seen", seen_done, 1'b1);
        chk("cmd_rdy_after", cmd_rdy, 1'b1);
    endtask

    initial begin
        int n;
        int c;
        #12;
        chk("rst_out", cru, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_level", fifo_level, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cmd_rdy", cmd_rdy, 1'b1);

        // ordered data, incrementing ids
        push_word({16{8'hA5}});
        push_word({16{8'hB6}});
        push_word({16{8'hC7}});
        issue(5'd2, 3, 1'b0, 0, 0);

        // id wrap and broadcast
        for (int i = 0; i < 3; i++) push_word({$urandom, $urandom, $urandom, $urandom});
        issue(5'd30, 3, 1'b0, 0, 0);
        for (int i = 0; i < 2; i++) push_word({$urandom, $urandom, $urandom, $urandom});
        issue(5'd7, 2, 1'b1, 0, 0);

        // empty FIFO, words arrive later
        issue(5'd12, 2, 1'b0, 4, 2);

        // full FIFO, dropped push, push+pop at level 7
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom});
        chk("full_wr_rdy", wr_rdy, 1'b0);
        push_word({32{4'hF}});
        issue(5'd3, 2, 1'b0, 1, 2);

        // zero-length command, then a short one
        issue(5'd9, 0, 1'b0, 0, 0);
        issue(5'd20, 2, 1'b0, 0, 0);

        // randomized commands
        for (int k = 0; k < 20; k++) begin
            n = $urandom_range(0, 4);
            for (int i = 0; i < n && mq.size() < 8; i++) push_word({$urandom, $urandom, $urandom, $urandom});
            c = $urandom_range(0, mq.size() < 4 ? mq.size() : 4);
            issue(5'($urandom), c, 1'($urandom), $urandom_range(1, 3), $urandom_range(0, 2));
        end

        // reset with words buffered mid-command
        while (mq.size() > 0) begin
            c = mq.size() < 4 ? mq.size() : 4;
            issue(5'd0, c, 1'b0, 0, 0);
        end
        for (int i = 0; i < 4; i++) push_word({$urandom, $urandom, $urandom, $urandom});
        cmd_vld = 1'b1;
        cmd_smc_id = 5'd9;
        cmd_word_cnt = 3'd4;
        cmd_broadcast = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);
        cmd_vld = 1'b0;
        step(1'b1, 1'b0, 5'd9, 1'b0);
        chk("pre_rst_level", fifo_level, 3);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out", cru, '0);
        chk("arst_done", done, 1'b0);
        chk("arst_level", fifo_level, 0);
        mq.delete();
        last = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("arst_cmd_rdy", cmd_rdy, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0);
        push_word({$urandom, $urandom, $urandom, $urandom});
        issue(5'd31, 1, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
